// File: rtl/driver_pkg.sv
// Shared types and constants for the vector fetch scheduler.
package driver_pkg;

    // Width of the exported outstanding-read counter.
    localparam int CNT_W = 8;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/updn_sat_cnt.sv
// Up/down counter that saturates at 0 and at MAX; simultaneous inc and dec cancel.
module updn_sat_cnt
    import driver_pkg::*;
#(
    parameter int W    = CNT_W,
    parameter int MAX  = 255,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] INIT_V = W'(INIT);
    localparam logic [W-1:0] ONE_V  = W'(1);

    // Count update: single step per edge, clamped at both ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= INIT_V;
        end else if (inc && !dec) begin
            if (value != MAX_V) begin
                value <= value + ONE_V;
            end
        end else if (dec && !inc) begin
            if (value != '0) begin
                value <= value - ONE_V;
            end
        end
    end

endmodule

// File: rtl/vctr_fetch_sched.sv
// Fetch scheduler: pops vector addresses, issues pipelined reads on the
// memory master port and forwards the returned data in order to the vector
// FIFO, never requesting more data than the vector FIFO has room for.
module vctr_fetch_sched
    import driver_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int VCTR_FIFO_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_program,
    input  logic              end_program,
    input  logic              addr_fifo_empty,
    input  logic [ADDR_W-1:0] addr_fifo_dout,
    output logic              addr_fifo_rd,
    output logic [ADDR_W-1:0] master_addr,
    output logic              master_rd,
    input  logic              master_wait_req,
    input  logic [DATA_W-1:0] master_data_in,
    input  logic              master_data_in_val,
    output logic [DATA_W-1:0] vctr_fifo_din,
    output logic              vctr_fifo_wr,
    input  logic              vctr_fifo_rd,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic [CNT_W-1:0]  outstanding_cnt,
    output logic              err_spurious
);

    localparam int CRED_W = $clog2(VCTR_FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] MAX_OUT_V = (CNT_W + 1)'(MAX_OUTSTANDING);

    fetch_state_t       state;
    logic [CRED_W-1:0]  credits;
    logic [CNT_W:0]     in_flight;
    logic               accept;
    logic               slot_free;
    logic               room;
    logic               stopping;
    logic               issue;
    logic               ret_ok;
    logic               spurious;

    // A held request is accepted on any edge where the slave does not stall.
    assign accept    = master_rd && !master_wait_req;
    // The request register can take a new address if empty or emptying now.
    assign slot_free = !master_rd || accept;
    // Reads in flight include the one still waiting on the slave.
    assign in_flight = {1'b0, outstanding_cnt} + {{CNT_W{1'b0}}, master_rd};
    assign room      = in_flight < MAX_OUT_V;
    // No new reads once the program is being stopped, even in the stop cycle.
    assign stopping  = end_program || !run_program;
    assign issue     = (state == FETCH) && !stopping && !addr_fifo_empty &&
                       (credits != '0) && room && slot_free;
    assign addr_fifo_rd = issue;

    // Returns are only legal while something is outstanding.
    assign ret_ok   = master_data_in_val && (outstanding_cnt != '0);
    assign spurious = master_data_in_val && (outstanding_cnt == '0);

    assign fetch_busy = (state != IDLE);

    // Reads accepted by the slave whose data has not come back yet.
    updn_sat_cnt #(
        .W    (CNT_W),
        .MAX  (MAX_OUTSTANDING),
        .INIT (0)
    ) u_outstanding (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .dec   (ret_ok),
        .value (outstanding_cnt)
    );

    // Free vector FIFO slots not yet promised to an issued read.
    updn_sat_cnt #(
        .W    (CRED_W),
        .MAX  (VCTR_FIFO_DEPTH),
        .INIT (VCTR_FIFO_DEPTH)
    ) u_credits (
        .clk   (clk),
        .reset (reset),
        .inc   (vctr_fifo_rd),
        .dec   (issue),
        .value (credits)
    );

    // Request register: load on issue, hold through stalls, drop after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            master_addr <= '0;
            master_rd   <= 1'b0;
        end else if (issue) begin
            master_addr <= addr_fifo_dout;
            master_rd   <= 1'b1;
        end else if (accept) begin
            master_rd   <= 1'b0;
        end
    end

    // Return path: one-cycle registered copy of valid returns into the vector FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vctr_fifo_din <= '0;
            vctr_fifo_wr  <= 1'b0;
        end else begin
            vctr_fifo_wr <= ret_ok;
            if (ret_ok) begin
                vctr_fifo_din <= master_data_in;
            end
        end
    end

    // Sequencer with registered done pulse and sticky spurious-return flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            fetch_done   <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_program) begin
                        state        <= FETCH;
                        err_spurious <= 1'b0;
                    end
                end
                FETCH: begin
                    if (stopping) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!master_rd && (outstanding_cnt == '0)) begin
                        state      <= IDLE;
                        fetch_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // A stray return wins over the clear on the same edge.
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule
